// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder/subtractor that consumes CHUNK bits per clock, LSB
//   slice first, and takes STEPS = WIDTH/CHUNK RUN cycles per operation.
//   Subtraction is a + ~b + ~cin, so cout reads as "not borrow".
//   WIDTH must be an integer multiple of CHUNK.
//
// Ports
//   clk    in          rising-edge clock
//   rst    in          synchronous active-high reset
//   start  in          begin an operation (only looked at in IDLE)
//   a, b   in  WIDTH   operands, captured at the accepting edge
//   cin    in          carry-in (add) / borrow-in (sub)
//   sub    in          0 = add, 1 = subtract
//   busy   out         high for the STEPS cycles of RUN
//   done   out         one-cycle pulse, result valid
//   sum    out WIDTH   result, held until the next done
//   cout   out         carry out of the MSB (not-borrow for sub)
//   ovf    out         signed overflow
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]       sa, sb;      // operand shift registers
    logic [WIDTH-1:0]       acc;         // partial result, filled from the top
    logic                   carry;
    logic [CW-1:0]          cnt;

    logic                   last;
    logic [CHUNK:0]         slice;
    logic [WIDTH+CHUNK-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_nxt;
    logic                   msb_cin;

    assign last = (cnt == CW'(STEPS - 1));

    always_comb begin
        slice   = {1'b0, sa[CHUNK-1:0]} + {1'b0, sb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        // New slice enters at the top; concatenation form keeps CHUNK == WIDTH legal.
        acc_cat = {slice[CHUNK-1:0], acc};
        acc_nxt = acc_cat[WIDTH+CHUNK-1:CHUNK];
        // Carry into the top bit of this slice, recovered from its sum bit.
        // Only meaningful on the final slice, where that bit is the MSB.
        msb_cin = slice[CHUNK-1] ^ sa[CHUNK-1] ^ sb[CHUNK-1];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b ^ {WIDTH{sub}};
                        carry <= cin ^ sub;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sa    <= sa >> CHUNK;
                    sb    <= sb >> CHUNK;
                    acc   <= acc_nxt;
                    carry <= slice[CHUNK];
                    cnt   <= cnt + CW'(1);
                    // Visible outputs change only once the whole word is ready.
                    if (last) begin
                        sum  <= acc_nxt;
                        cout <= slice[CHUNK];
                        ovf  <= msb_cin ^ slice[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---- two 8-bit instances share operand inputs, each has its own start
    bit         sel = 1'b0;      // 0: CHUNK=1 instance, 1: CHUNK=4 instance
    logic       st  = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0, sub8 = 1'b0;
    logic       start81, start84;
    logic       busy81, done81, cout81, ovf81;
    logic       busy84, done84, cout84, ovf84;
    logic [7:0] sum81, sum84;

    assign start81 = st & ~sel;
    assign start84 = st & sel;

    serial_adder #(.WIDTH(8), .CHUNK(1)) u81 (
        .clk(clk), .rst(rst), .start(start81), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .ovf(ovf81));
    serial_adder #(.WIDTH(8), .CHUNK(4)) u84 (
        .clk(clk), .rst(rst), .start(start84), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .ovf(ovf84));

    logic       o_busy, o_done, o_cout, o_ovf;
    logic [7:0] o_sum;
    assign o_busy = sel ? busy84 : busy81;
    assign o_done = sel ? done84 : done81;
    assign o_sum  = sel ? sum84  : sum81;
    assign o_cout = sel ? cout84 : cout81;
    assign o_ovf  = sel ? ovf84  : ovf81;

    // ---- three 4-bit instances driven together
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0, sub4 = 1'b0;
    logic       busy41, done41, cout41, ovf41;
    logic       busy42, done42, cout42, ovf42;
    logic       busy44, done44, cout44, ovf44;
    logic [3:0] sum41, sum42, sum44;

    serial_adder #(.WIDTH(4), .CHUNK(1)) u41 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .busy(busy41), .done(done41), .sum(sum41), .cout(cout41), .ovf(ovf41));
    serial_adder #(.WIDTH(4), .CHUNK(2)) u42 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .busy(busy42), .done(done42), .sum(sum42), .cout(cout42), .ovf(ovf42));
    serial_adder #(.WIDTH(4), .CHUNK(4)) u44 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .busy(busy44), .done(done44), .sum(sum44), .cout(cout44), .ovf(ovf44));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts one 8-bit operation at the coming edge (called at a negedge).
    // Reports edges from E0 to done, RUN cycles and done pulses seen in a
    // bounded 20-cycle window. With scramble set, start and all operands are
    // randomised every RUN cycle. sum must hold its old value while busy.
    task automatic run8(input bit s, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb, input bit scramble,
                        output int lat, output int busy_n, output int done_n);
        logic [7:0] pre;
        sel  = s;
        a8   = av;
        b8   = bv;
        cin8 = ci;
        sub8 = sb;
        st   = 1'b1;
        #1 pre = o_sum;
        lat = 0; busy_n = 0; done_n = 0;
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            if (o_busy) begin
                busy_n++;
                chk("hold_during_run", {24'h0, o_sum}, {24'h0, pre});
            end
            if (o_done) begin
                done_n++;
                if (lat == 0) lat = k;
            end
            if (scramble && o_busy) begin
                st   = 1'($urandom_range(0, 1));
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                cin8 = 1'($urandom_range(0, 1));
                sub8 = 1'($urandom_range(0, 1));
            end else begin
                st = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    int lat, bn, dn;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        sel = 1'b0;
        #1;
        chk("rst_busy", {31'h0, o_busy}, 0);
        chk("rst_done", {31'h0, o_done}, 0);
        chk("rst_sum",  {24'h0, o_sum},  0);
        chk("rst_cout", {31'h0, o_cout}, 0);
        chk("rst_ovf",  {31'h0, o_ovf},  0);
        @(negedge clk);

        // 7F + 01, first edge after reset release
        rst = 1'b0;
        run8(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, lat, bn, dn);
        chk("r21_lat",  lat, 9);
        chk("r21_busy", bn, 8);
        chk("r21_dn",   dn, 1);
        chk("r21_sum",  {24'h0, o_sum}, 32'h80);
        chk("r21_cout", {31'h0, o_cout}, 0);
        chk("r21_ovf",  {31'h0, o_ovf}, 1);

        // 05 - 07
        run8(1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, lat, bn, dn);
        chk("r22_sum",  {24'h0, o_sum}, 32'hFE);
        chk("r22_cout", {31'h0, o_cout}, 0);
        chk("r22_ovf",  {31'h0, o_ovf}, 0);

        // CHUNK=4: FF + 01 + 1
        run8(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, lat, bn, dn);
        chk("r23_lat",  lat, 3);
        chk("r23_busy", bn, 2);
        chk("r23_dn",   dn, 1);
        chk("r23_sum",  {24'h0, o_sum}, 32'h01);
        chk("r23_cout", {31'h0, o_cout}, 1);
        chk("r23_ovf",  {31'h0, o_ovf}, 0);

        // CHUNK=4: 80 - 01, signed overflow on subtract
        run8(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, lat, bn, dn);
        chk("c4sub_sum",  {24'h0, o_sum}, 32'h7F);
        chk("c4sub_cout", {31'h0, o_cout}, 1);
        chk("c4sub_ovf",  {31'h0, o_ovf}, 1);

        // Reset in the middle of RUN, then reset colliding with start
        sel = 1'b0; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b0; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("r24_busy", {31'h0, o_busy}, 0);
        chk("r24_done", {31'h0, o_done}, 0);
        chk("r24_sum",  {24'h0, o_sum}, 0);
        chk("r24_cout", {31'h0, o_cout}, 0);
        chk("r24_ovf",  {31'h0, o_ovf}, 0);
        st = 1'b1;
        @(negedge clk);
        chk("r19_nostart", {31'h0, o_busy}, 0);
        rst = 1'b0;
        run8(1'b0, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, lat, bn, dn);
        chk("r24_lat",  lat, 9);
        chk("r24_sum",  {24'h0, o_sum}, 32'h30);
        chk("r24_cout", {31'h0, o_cout}, 0);
        chk("r24_ovf",  {31'h0, o_ovf}, 0);

        // Operands and start disturbed during RUN: 3C - 11 - 1
        run8(1'b0, 8'h3C, 8'h11, 1'b1, 1'b1, 1'b1, lat, bn, dn);
        chk("r25_dn",   dn, 1);
        chk("r25_busy", bn, 8);
        chk("r25_sum",  {24'h0, o_sum}, 32'h2A);
        chk("r25_cout", {31'h0, o_cout}, 1);
        chk("r25_ovf",  {31'h0, o_ovf}, 0);

        // Exhaustive 4-bit sweep across CHUNK = 1, 2, 4
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    for (int si = 0; si < 2; si++) begin
                        int   r, sa, sb, sr;
                        logic [4:0] e5;
                        logic eo;
                        a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); sub4 = 1'(si);
                        start4 = 1'b1;
                        @(negedge clk);
                        start4 = 1'b0;
                        repeat (5) @(negedge clk);
                        r  = si ? ai + (15 - bi) + (1 - ci) : ai + bi + ci;
                        e5 = 5'(r);
                        sa = ai >= 8 ? ai - 16 : ai;
                        sb = bi >= 8 ? bi - 16 : bi;
                        sr = si ? sa - sb - ci : sa + sb + ci;
                        eo = (sr > 7) || (sr < -8);
                        chk("x41_res", {27'h0, cout41, sum41}, {27'h0, e5});
                        chk("x41_ovf", {31'h0, ovf41}, {31'h0, eo});
                        chk("x42_res", {27'h0, cout42, sum42}, {27'h0, e5});
                        chk("x42_ovf", {31'h0, ovf42}, {31'h0, eo});
                        chk("x44_res", {27'h0, cout44, sum44}, {27'h0, e5});
                        chk("x44_ovf", {31'h0, ovf44}, {31'h0, eo});
                    end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 1, giving the bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK, and STEPS = WIDTH/CHUNK.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports, one per line:
 clk    in   1      clock, rising edge
 rst    in   1      synchronous active-high reset
 start  in   1      request operation; sampled only in IDLE
 a      in   WIDTH  operand A
 b      in   WIDTH  operand B
 cin    in   1      carry-in (add) / borrow-in (sub)
 sub    in   1      0 = add, 1 = subtract
 busy   out  1      high while in RUN
 done   out  1      one-cycle result-valid pulse
 sum    out  WIDTH  result
 cout   out  1      carry-out (add) / not-borrow (sub)
 ovf    out  1      two's-complement signed overflow

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-006 In IDLE, when start=1 at a rising edge (E0):
 - a and b^{WIDTH{sub}} SHALL be latched into internal shift registers.
 - The carry register SHALL load cin^sub.
 - The step counter SHALL clear.
 - The state SHALL go to RUN.
REQ-007 Add mode SHALL compute a+b+cin; subtract mode SHALL compute a+~b+~cin, i.e. a-b-cin.
REQ-008 At each RUN edge, one CHUNK-bit slice, LSB slice first, SHALL be added with the carry register, the slice result shifted into the sum register, the carry register updated, and the counter incremented.
REQ-009 At the edge that completes slice STEPS-1 (edge E_STEPS), the state SHALL go to DONE.
REQ-010 The outputs at that edge SHALL be updated as follows:
 - sum = full result.
 - cout = carry out of the MSB.
 - ovf = carry into the MSB XOR carry out of the MSB.
REQ-011 done SHALL be 1 only in DONE, i.e. for exactly one cycle; the next edge SHALL return the state to IDLE.
REQ-012 busy SHALL be 1 exactly in RUN, i.e. for STEPS cycles.
REQ-013 Latency from the start-sampling edge E0 to done high SHALL be STEPS+1 edges; the minimum start-to-start spacing SHALL be STEPS+2 cycles.
REQ-014 start SHALL be ignored in RUN and DONE; no queuing.
REQ-015 Changes on a, b, cin or sub after E0 SHALL NOT affect the operation in progress.
REQ-016 sum, cout and ovf SHALL hold their last result from DONE through IDLE until the next DONE, and SHALL NOT show partial values during RUN.
REQ-017 The counter SHALL be sized ceil(log2(STEPS+1)) bits with no wrap-around inside an operation; STEPS=1 (CHUNK=WIDTH) SHALL be legal and give one RUN cycle.

Reset
REQ-018 rst=1 at any edge, including mid-RUN or in DONE, SHALL force:
 - state = IDLE;
 - busy = done = 0;
 - sum = 0, cout = 0, ovf = 0;
 - internal counter, carry and shift registers = 0.
REQ-019 rst SHALL take priority over start at the same edge; no operation SHALL begin at that edge.
REQ-020 The first start SHALL be accepted at the first edge after rst deasserts.

Verification
REQ-021 WIDTH=8, CHUNK=1: a=8'h7F, b=8'h01, cin=0, sub=0 -> done exactly 9 edges after E0, sum=8'h80, cout=0, ovf=1; busy high for 8 cycles.
REQ-022 WIDTH=8, CHUNK=1: a=8'h05, b=8'h07, cin=0, sub=1 -> sum=8'hFE, cout=0, ovf=0.
REQ-023 WIDTH=8, CHUNK=4: a=8'hFF, b=8'h01, cin=1, sub=0 -> done 3 edges after E0, sum=8'h01, cout=1, ovf=0.
REQ-024 Assert rst during RUN step 3, then start a=8'h10, b=8'h20 -> outputs 0 during reset, then sum=8'h30, cout=0, ovf=0; no residue from the aborted operation.
REQ-025 During RUN, pulse start and toggle a, b, cin and sub -> the result matches the E0 operands, and only one done pulse is produced.
REQ-026 WIDTH=4, CHUNK in {1, 2, 4}: all a, b, cin, sub combinations -> {cout, sum} equal to a+b+cin (add) or a+~b+~cin (sub) in 5 bits, and ovf equal to the signed-overflow model.
